// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: grants write/read bursts and auto-refresh, sequencing ACTIVE -> RD/WR -> PRECHARGE.
// Build option: define ARB_WRITE_PRIORITY_EN to give writes fixed priority over reads. T_RCD must be >= 2.
module sdram_cmd_arbiter #(
  parameter int T_RCD      = 2,
  parameter int T_RP       = 2,
  parameter int T_WR       = 2,
  parameter int T_RFC      = 7,
  parameter int CAS_LAT    = 3,
  parameter int REF_PERIOD = 780
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [23:0] sdram_wr_addr,
  input  logic [23:0] sdram_rd_addr,
  input  logic [9:0]  br_length,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic        rd_data_valid,
  output logic        busy,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  localparam int REF_W = $clog2(REF_PERIOD);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_PERIOD - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REFRESH,
    S_TRFC_WAIT,
    S_ACTIVE,
    S_TRCD_WAIT,
    S_WRITE,
    S_WR_RECOVERY,
    S_READ,
    S_PRECHARGE,
    S_TRP_WAIT
  } state_t;

  state_t             state;
  logic [9:0]         cnt;
  logic [9:0]         len_q;
  logic [1:0]         ba_q;
  logic [8:0]         col_q;
  logic               is_wr_q;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pending;
  logic [CAS_LAT-1:0] rd_pipe;

  logic        wr_ok;
  logic        rd_ok;
  logic        grant_wr;
  logic        grant;
  logic        ref_issue;
  logic [23:0] sel_addr;

`ifdef ARB_WRITE_PRIORITY_EN
  always_comb begin
    grant_wr = wr_ok;
  end
`else
  // rr_wr high means the write side wins the next simultaneous request
  logic rr_wr;

  always_comb begin
    grant_wr = wr_ok && (!rd_ok || rr_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_wr <= 1'b1;
    end else if (grant) begin
      rr_wr <= !grant_wr;
    end
  end
`endif

  always_comb begin
    wr_ok     = wr_req && (br_length != '0);
    rd_ok     = rd_req && (br_length != '0);
    ref_issue = (state == S_IDLE) && init_done && ref_pending;
    grant     = (state == S_IDLE) && init_done && !ref_pending && (wr_ok || rd_ok);
    sel_addr  = grant_wr ? sdram_wr_addr : sdram_rd_addr;
  end

  // A wrap while a refresh is still pending leaves a single pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (ref_issue) begin
        ref_pending <= 1'b0;
      end
      if (!init_done) begin
        ref_cnt <= '0;
      end else if (ref_cnt == REF_LAST) begin
        ref_cnt     <= '0;
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + REF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[CAS_LAT-2:0], rd_ack};
    end
  end

  assign rd_data_valid = rd_pipe[CAS_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sdram_cmd <= CMD_NOP;
      sdram_ba  <= '0;
      sdram_a   <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      ba_q      <= '0;
      col_q     <= '0;
      is_wr_q   <= 1'b0;
    end else begin
      sdram_cmd <= CMD_NOP;
      unique case (state)
        S_IDLE: begin
          if (ref_issue) begin
            state     <= S_REFRESH;
            sdram_cmd <= CMD_REF;
            busy      <= 1'b1;
          end else if (grant) begin
            state     <= S_ACTIVE;
            sdram_cmd <= CMD_ACT;
            busy      <= 1'b1;
            is_wr_q   <= grant_wr;
            sdram_ba  <= sel_addr[23:22];
            sdram_a   <= sel_addr[21:9];
            ba_q      <= sel_addr[23:22];
            col_q     <= sel_addr[8:0];
            len_q     <= br_length;
          end
        end
        S_REFRESH: begin
          state <= S_TRFC_WAIT;
          cnt   <= 10'(T_RFC - 1);
        end
        S_TRFC_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        S_ACTIVE: begin
          state <= S_TRCD_WAIT;
          cnt   <= 10'(T_RCD - 2);
        end
        S_TRCD_WAIT: begin
          if (cnt == '0) begin
            sdram_ba <= ba_q;
            sdram_a  <= {4'b0000, col_q};
            cnt      <= len_q - 10'd1;
            if (is_wr_q) begin
              state     <= S_WRITE;
              sdram_cmd <= CMD_WRITE;
              wr_ack    <= 1'b1;
            end else begin
              state     <= S_READ;
              sdram_cmd <= CMD_READ;
              rd_ack    <= 1'b1;
            end
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        S_WRITE: begin
          if (cnt == '0) begin
            wr_ack <= 1'b0;
            state  <= S_WR_RECOVERY;
            cnt    <= 10'(T_WR - 1);
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        S_WR_RECOVERY: begin
          if (cnt == '0) begin
            state     <= S_PRECHARGE;
            sdram_cmd <= CMD_PRE;
            sdram_a   <= 13'h0400;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        S_READ: begin
          // precharge coincides with the first cycle rd_ack is low
          if (cnt == '0) begin
            rd_ack    <= 1'b0;
            state     <= S_PRECHARGE;
            sdram_cmd <= CMD_PRE;
            sdram_a   <= 13'h0400;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        S_PRECHARGE: begin
          state <= S_TRP_WAIT;
          cnt   <= 10'(T_RP - 1);
        end
        S_TRP_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Responder side of the SDRAM FIFO controller handshake.
- Samples wr_req/rd_req with their 24-bit burst addresses and arbitrates between them and periodic auto-refresh.
- Sequences each burst as ACTIVE -> WRITE/READ (full-page) -> PRECHARGE.
- Returns wr_ack/rd_ack high for exactly the data phase; the requester advances its address on the falling edge of the ack.

Parameters:
- T_RCD, 2, cycles from ACTIVE to READ/WRITE
- T_RP, 2, NOP cycles after PRECHARGE
- T_WR, 2, NOP cycles between last write data and PRECHARGE
- T_RFC, 7, NOP cycles after AUTO REFRESH
- CAS_LAT, 3, read latency in cycles (2 or 3)
- REF_PERIOD, 780, cycles between refresh requests (7.8 us at 100 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  SDRAM power-up init complete; block idle until high
- wr_req  in  1  write burst request (level)
- rd_req  in  1  read burst request (level)
- sdram_wr_addr  in  24  write address {ba[1:0], row[12:0], col[8:0]}
- sdram_rd_addr  in  24  read address, same mapping
- br_length  in  10  burst length in words, 1..512
- wr_ack  out  1  high during write data phase; requester pops FIFO
- rd_ack  out  1  high while READ burst runs
- rd_data_valid  out  1  SDRAM read data valid; requester pushes FIFO
- busy  out  1  high in every state except IDLE
- sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n}
- sdram_ba  out  2  bank address
- sdram_a  out  13  row/column address bus

Behaviour:
- Clocking and reset: one clock (clk); rst_n asynchronous, active-low. All outputs are registered.
- Reset values: sdram_cmd=4'b0111 (NOP), sdram_ba=0, sdram_a=0, all other outputs 0, state IDLE, refresh counter 0, round-robin pointer = write.
- Reset asserted mid-burst aborts immediately to these values; no PRECHARGE is issued.
- Command encodings: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010 (A10=1, all banks), AUTO REFRESH 0001.
- States: IDLE, REFRESH, TRFC_WAIT, ACTIVE, TRCD_WAIT, WRITE, WR_RECOVERY, READ, PRECHARGE, TRP_WAIT.
- init_done=0: stay in IDLE issuing NOP; refresh counter held at 0.
- Refresh counter: counts to REF_PERIOD-1, then sets ref_pending and wraps. ref_pending is cleared in the cycle AUTO REFRESH is issued. Another wrap while still pending stays pending (no count stacking).
- IDLE priority: ref_pending > request.
  - REFRESH issues AUTO REFRESH for 1 cycle, then TRFC_WAIT for T_RFC NOP cycles, then IDLE.
- Requests are sampled only in IDLE; br_length==0 is ignored.
- Both requests pending: round-robin; the side not served last wins. Pointer updates on each grant.
- Grant latches the address and br_length.
  - Next cycle: ACTIVE with ba=addr[23:22], a=addr[21:9].
  - Then T_RCD-1 NOP cycles.
  - Then the READ/WRITE command with a={4'b0, addr[8:0]} (A10=0).
- Write data phase: wr_ack high for exactly br_length cycles, starting in the cycle WRITE is issued; NOP is driven after the first cycle. Then WR_RECOVERY for T_WR NOP cycles, then PRECHARGE.
- Read: rd_ack high for br_length cycles from the READ cycle. PRECHARGE is issued in the cycle rd_ack first drops.
- rd_data_valid is rd_ack delayed by CAS_LAT cycles through a shift register; it continues through PRECHARGE/TRP_WAIT.
- PRECHARGE is 1 cycle, then TRP_WAIT for T_RP NOP cycles, then IDLE.
- This guarantees at least 3 cycles from the ack falling edge to the next IDLE sampling, so the requester's updated address (2-cycle edge detect) is valid.
- Bursts never cross a row. Column wrap within the page is SDRAM behaviour and is not checked.
- Requests and address changes outside IDLE are ignored.

Optional Feature:
- Macro ARB_WRITE_PRIORITY_EN.
- Defined: on simultaneous wr_req and rd_req, write always wins; the round-robin pointer is unused.
- Undefined: round-robin as above.
- Refresh priority is unchanged either way.

Test Plan:
- Reset then init_done=1, no requests -> AUTO REFRESH at cycle 780 after init_done, next at 1560; NOP otherwise.
- wr_req, addr 24'h40_0A10, br_length 16 -> ACTIVE ba=1, a=0x005. WRITE T_RCD cycles later with a=0x010. wr_ack high exactly 16 cycles, 2 NOP, PRECHARGE with a[10]=1, 2 NOP, busy low.
- rd_req, br_length 8, CAS_LAT 3 -> rd_ack 8 cycles from READ. rd_data_valid 8 cycles starting 3 cycles after READ. PRECHARGE in the cycle after the last rd_ack.
- wr_req and rd_req held high together -> grants alternate W,R,W,R. With ARB_WRITE_PRIORITY_EN, all grants are W.
- ref_pending and wr_req together in IDLE -> AUTO REFRESH first, 7 NOP, then ACTIVE.
- rst_n pulsed low mid write burst -> outputs immediately NOP/0, wr_ack=0. After release, a new request is served normally.
